// File: rtl/rob_pkg.sv
// rob_pkg: shared entry type and width helpers for the reorder buffer.
`ifndef PROJ_LOG_PHYS
`define PROJ_LOG_PHYS 6
`endif
`ifndef PROJ_LOG_ARCH
`define PROJ_LOG_ARCH 5
`endif
package rob_pkg;
    localparam int ROB_DEPTH = 32;
    localparam int LOG_PHYS  = `PROJ_LOG_PHYS;
    localparam int LOG_ARCH  = `PROJ_LOG_ARCH;

    function automatic int tag_w(input int depth);
        return $clog2(depth);
    endfunction

    typedef struct packed {
        logic [31:0]         pc;
        logic [31:0]         alt_pc;
        logic                has_dest;
        logic [LOG_ARCH-1:0] arch;
        logic [LOG_PHYS-1:0] phys;
        logic [LOG_PHYS-1:0] prev_phys;
        logic                valid;
        logic                done;
        logic                mispredict;
    } rob_entry_t;
endpackage

// File: rtl/rob_ptr.sv
// rob_ptr: ring pointer with an extra wrap bit that toggles on each pass.
module rob_ptr #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W:0]   ptr
);
    always_ff @(posedge clk or posedge rst)
        if (rst) ptr <= '0;
        else if (clr) ptr <= '0;
        else if (inc) ptr <= ptr + 1'b1;
endmodule

// File: rtl/rob.sv
// rob: in-order retire reorder buffer that flushes on a mispredicted branch at the head.
// Optional ROB_PERF_COUNTERS_EN adds saturating commit/flush counters.
module rob
    import rob_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int TAG_W = tag_w(DEPTH)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                Alloc_valid,
    input  logic [31:0]         Alloc_pc,
    input  logic [31:0]         Alloc_alt_pc,
    input  logic                Alloc_has_dest,
    input  logic [LOG_ARCH-1:0] Alloc_arch,
    input  logic [LOG_PHYS-1:0] Alloc_phys,
    input  logic [LOG_PHYS-1:0] Alloc_prev_phys,
    output logic [TAG_W-1:0]    Alloc_tag,
    output logic                ROB_full,
    output logic                ROB_empty,
    input  logic                Complete_valid,
    input  logic [TAG_W-1:0]    Complete_tag,
    input  logic                Complete_mispredict,
    output logic                Commit_valid,
    output logic [LOG_ARCH-1:0] Commit_arch,
    output logic [LOG_PHYS-1:0] Commit_phys,
    output logic                Commit_has_dest,
    output logic                Free_valid,
    output logic [LOG_PHYS-1:0] Free_phys,
    output logic                Flush,
    output logic [31:0]         Flush_pc
`ifdef ROB_PERF_COUNTERS_EN
    ,
    output logic [31:0]         Perf_commits,
    output logic [31:0]         Perf_flushes
`endif
);
    rob_entry_t       ents [DEPTH];
    logic [TAG_W:0]   head, tail, count;
    logic [TAG_W-1:0] hidx, tidx;
    logic             do_alloc, do_commit, cmp_ok;

    assign hidx      = head[TAG_W-1:0];
    assign tidx      = tail[TAG_W-1:0];
    assign Alloc_tag = tidx;
    assign ROB_full  = (hidx == tidx) && (head[TAG_W] != tail[TAG_W]);
    assign ROB_empty = (count == '0);
    // Nothing moves while the squash pulse is out; the whole ring is cleared on that edge.
    assign do_alloc  = Alloc_valid && !ROB_full && !Flush;
    assign do_commit = !Flush && ents[hidx].valid && ents[hidx].done;
    assign cmp_ok    = !Flush && Complete_valid && ents[Complete_tag].valid;

    rob_ptr #(.W(TAG_W)) u_head (.clk(CLK), .rst(RESET), .inc(do_commit), .clr(Flush), .ptr(head));
    rob_ptr #(.W(TAG_W)) u_tail (.clk(CLK), .rst(RESET), .inc(do_alloc), .clr(Flush), .ptr(tail));

    always_ff @(posedge CLK or posedge RESET)
        if (RESET) count <= '0;
        else if (Flush) count <= '0;
        else count <= count + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(do_commit);

    always_ff @(posedge CLK or posedge RESET)
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) ents[i] <= '0;
        end else if (Flush) begin
            for (int i = 0; i < DEPTH; i++) ents[i].valid <= 1'b0;
        end else begin
            if (cmp_ok) begin
                ents[Complete_tag].done       <= 1'b1;
                ents[Complete_tag].mispredict <= Complete_mispredict;
            end
            if (do_commit) ents[hidx].valid <= 1'b0;
            if (do_alloc)
                ents[tidx] <= '{pc: Alloc_pc, alt_pc: Alloc_alt_pc, has_dest: Alloc_has_dest,
                                arch: Alloc_arch, phys: Alloc_phys, prev_phys: Alloc_prev_phys,
                                valid: 1'b1, done: 1'b0, mispredict: 1'b0};
        end

    always_ff @(posedge CLK or posedge RESET)
        if (RESET) begin
            Commit_valid    <= 1'b0;
            Commit_arch     <= '0;
            Commit_phys     <= '0;
            Commit_has_dest <= 1'b0;
            Free_valid      <= 1'b0;
            Free_phys       <= '0;
            Flush           <= 1'b0;
            Flush_pc        <= '0;
        end else begin
            Commit_valid <= do_commit;
            Free_valid   <= do_commit && ents[hidx].has_dest;
            Flush        <= do_commit && ents[hidx].mispredict;
            if (do_commit) begin
                Commit_arch     <= ents[hidx].arch;
                Commit_phys     <= ents[hidx].phys;
                Commit_has_dest <= ents[hidx].has_dest;
                Free_phys       <= ents[hidx].prev_phys;
                Flush_pc        <= ents[hidx].alt_pc;
            end
        end

`ifdef ROB_PERF_COUNTERS_EN
    always_ff @(posedge CLK or posedge RESET)
        if (RESET) begin
            Perf_commits <= '0;
            Perf_flushes <= '0;
        end else begin
            if (Commit_valid && ~&Perf_commits) Perf_commits <= Perf_commits + 1'b1;
            if (Flush && ~&Perf_flushes) Perf_flushes <= Perf_flushes + 1'b1;
        end
`endif
endmodule

// File: doc/rob.md
# rob

Reorder buffer directly downstream of the rename stage. Accepts one renamed instruction per cycle into a circular buffer and records execution completion by tag. Retires in program order at one instruction per cycle, returning the superseded physical register to the free list. On a mispredicted branch reaching the head, it flushes the machine and redirects fetch.

## Interface
- DEPTH, 32, number of entries; power of two, minimum 4
- TAG_W, $clog2(DEPTH), entry tag width
- LOG_PHYS, `PROJ_LOG_PHYS, physical register index width
- LOG_ARCH, `PROJ_LOG_ARCH, architectural register index width

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high
- Alloc_valid  in  1  rename presents an entry this cycle
- Alloc_pc  in  32  instruction address
- Alloc_alt_pc  in  32  redirect target used if the branch mispredicts
- Alloc_has_dest  in  1  instruction writes a register
- Alloc_arch  in  LOG_ARCH  destination architectural register
- Alloc_phys  in  LOG_PHYS  newly mapped physical register
- Alloc_prev_phys  in  LOG_PHYS  prior mapping of Alloc_arch
- Alloc_tag  out  TAG_W  slot the next accepted allocation receives (= tail)
- ROB_full  out  1  count == DEPTH
- ROB_empty  out  1  count == 0
- Complete_valid  in  1  execution finished
- Complete_tag  in  TAG_W  tag of the finished entry
- Complete_mispredict  in  1  the finished branch took the alternate path
- Commit_valid  out  1  one entry retired (registered pulse)
- Commit_arch  out  LOG_ARCH  retired architectural register
- Commit_phys  out  LOG_PHYS  retired physical register (R-RAT update)
- Commit_has_dest  out  1  retired entry wrote a register
- Free_valid  out  1  Free_phys returns to the free list
- Free_phys  out  LOG_PHYS  Alloc_prev_phys of the retired entry
- Flush  out  1  one-cycle squash pulse
- Flush_pc  out  32  fetch redirect address, valid with Flush

## Operation
- State: head and tail pointers of TAG_W+1 bits (the extra bit is a wrap bit); count of TAG_W+1 bits; per-entry valid, done, and mispredict bits plus payload.
- Allocate when Alloc_valid && !ROB_full. Write the payload at tail, set valid, clear done and mispredict, then tail+1. Alloc_valid while full is ignored, and rename must hold the entry.
- Complete: if the slot is valid, set done and latch Complete_mispredict. Completion to an invalid slot is ignored.
- Commit: if head is valid && done, retire it. Pulse Commit_valid, drive the Commit_* fields, and pulse Free_valid only if has_dest. Clear valid, then head+1.
- Mispredict at commit: retire normally, and in the same cycle pulse Flush with Flush_pc = the entry's alt_pc. On the next edge, clear all valid bits, set head = tail = count = 0, and ignore allocation in that cycle.
- Same-cycle alloc and commit: count is unchanged. ROB_full is evaluated on the pre-commit count, so no allocation happens into a slot freed that same cycle.
- Pointer wrap: DEPTH-1 → 0 with the wrap bit toggling. Full = indices equal and wrap bits differ.
- Reset: all outputs 0, pointers 0, valid bits cleared. ROB_empty = 1, Alloc_tag = 0. Reset mid-flush discards the flush.

## Timing
- ROB_full, ROB_empty, and Alloc_tag are combinational from registered state only.
- Commit_*, Free_*, and Flush_* are registered and asserted the cycle after the edge on which head is valid && done.
- Complete-to-commit: done set at edge N; commit outputs are visible in cycle N+1 at the earliest.
- A completion and a commit of the same slot in the same cycle never occur (done is not yet set).

## Configuration
- ROB_PERF_COUNTERS_EN defined: add outputs Perf_commits (32-bit, +1 per commit) and Perf_flushes (32-bit, +1 per Flush). Both reset to 0 and saturate at all-ones.
- Undefined: the ports and counters are absent; the rest of the behaviour is identical.

## Structure
- Shared package rob_pkg:
  - rob_entry_t typedef (pc, alt_pc, has_dest, arch, phys, prev_phys, valid, done, mispredict)
  - TAG_W derivation
  - reuse of `PROJ_LOG_PHYS / `PROJ_LOG_ARCH from config.v
- One sub-module, rob_ptr: a TAG_W+1-bit wrap-aware pointer with increment and clear.

## Test plan
- Reset: assert RESET mid-cycle → all outputs 0, ROB_empty=1, Alloc_tag=0 asynchronously.
- In-order retire: allocate tags 0,1,2 (arch 5,6,7; prev_phys 10,11,12), complete in order 2,0,1 → commits for arch 5,6,7 on consecutive cycles, Free_phys 10,11,12.
- Full: 32 allocations with no completion → ROB_full=1. The 33rd Alloc_valid is refused and Alloc_tag stays 0. Complete tag 0 → one commit, then ROB_full=0.
- No-dest entry: Alloc_has_dest=0, complete → Commit_valid=1, Free_valid=0.
- Mispredict: allocate 4 entries, tag 1 with alt_pc 0x00400100; complete tag 0, then tag 1 with mispredict → tag 1 commits with Flush=1 and Flush_pc=0x00400100. Next cycle ROB_empty=1 and Alloc_tag=0.
- Wrap: run 40 alloc/commit pairs → tags wrap 31→0, with no spurious full or empty.
